fetch_redirect_unit: RTL
========================

Name: fetch_redirect_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Owns the PC and the IF/ID pipeline register.
- Drives a wait-state instruction-memory handshake.
- Consumes switch_branch and the branch target from the EX-stage branch control, and redirects fetch on a taken branch.
- Squashes wrong-path work: inserts IF/ID bubbles and pulses a flush to ID/EX.

Parameters:
- PC_WIDTH, 64, width of PC and branch target.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, encoding placed in if_id_instr when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- switch_branch  in  1  taken-branch redirect from EX-stage branch control.
- branch_target  in  PC_WIDTH  redirect address, valid when switch_branch=1.
- stall  in  1  hazard-unit stall; IF/ID must hold.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address.
- imem_ready  in  1  memory completes the request this cycle.
- imem_rdata  in  INSTR_WIDTH  instruction, valid when imem_req&imem_ready.
- pc_out  out  PC_WIDTH  current fetch PC.
- if_id_pc  out  PC_WIDTH  PC of the instruction held in IF/ID.
- if_id_instr  out  INSTR_WIDTH  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- flush_id_ex  out  1  combinational copy of switch_branch; squashes ID/EX.

Behaviour:
- Reset (async assert, any state): state=RUN, pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, holding register cleared. imem_req=0 while reset is low. First request is issued on the first cycle after deassertion.
- Handshake: a request is accepted on a cycle with imem_req&imem_ready. Once imem_req rises, imem_req and imem_addr are held until acceptance.
- imem_addr=pc in RUN and DROP.
- PC increment is pc+4 modulo 2^PC_WIDTH (wraps silently). branch_target[1:0] is forced to 0 before use.
- Priority in every state: switch_branch > stall > normal.
- RUN (imem_req=1):
  - accept & switch_branch: discard rdata; pc<=target; if_id_valid<=0.
  - accept & stall: hold_instr<=rdata; hold_pc<=pc; pc<=pc+4; go HOLD; IF/ID unchanged.
  - accept, no stall: IF/ID<={pc,rdata,1}; pc<=pc+4. Zero fetch bubbles when imem_ready stays high.
  - no accept & switch_branch: tgt_reg<=target; if_id_valid<=0; go DROP.
  - no accept & stall: IF/ID unchanged.
  - no accept, otherwise: if_id_valid<=0, if_id_instr<=NOP_INSTR.
- DROP (imem_req=1, addr=stale pc): completes the outstanding wrong-path fetch and discards it.
  - switch_branch in DROP: tgt_reg<=target (newest wins).
  - accept: pc<=tgt_reg, or branch_target if switch_branch is high that same cycle; go RUN.
  - if_id_valid=0 throughout DROP.
- HOLD (imem_req=0):
  - switch_branch: drop held instruction; pc<=target; if_id_valid<=0; go RUN.
  - stall: stay in HOLD.
  - !stall: IF/ID<={hold_pc,hold_instr,1}; go RUN.
- Whenever switch_branch=1, if_id_valid is 0 the next cycle, regardless of stall.
- pc_out always equals the pc register.

Optional Feature:
- Macro: FETCH_BRANCH_STATS_EN.
- Defined:
  - Adds output port taken_branch_count [31:0], reset 0.
  - Increments on every clk edge with switch_branch=1.
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready tied 1, RESET_PC=0 -> imem_addr 0,4,8 on consecutive cycles; if_id_valid=1 from the second cycle; if_id_pc lags pc_out by 1.
- switch_branch=1 with target 0x103 while in RUN accepting -> flush_id_ex=1 that cycle; next cycle pc_out=0x100, if_id_valid=0.
- imem_ready=0 for 3 cycles at addr 0x20, switch_branch pulse with target 0x80 in cycle 1 -> imem_addr stays 0x20 until ready; rdata discarded; next request at 0x80.
- stall=1 when fetch at 0x40 accepted -> IF/ID unchanged; imem_req=0 while stalled; on stall release IF/ID gets pc 0x40 with the held instruction; next fetch at 0x44.
- pc=0xFFFF_FFFF_FFFF_FFFC, accept -> pc wraps to 0. Async reset asserted mid-DROP -> immediate RUN, pc=RESET_PC, if_id_valid=0.
- FETCH_BRANCH_STATS_EN defined: 5 switch_branch pulses -> taken_branch_count=5; preload near max -> holds 0xFFFFFFFF.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch stage: owns the PC and IF/ID register, drives a wait-state imem handshake,
// and redirects/squashes on taken branches. Optional taken-branch counter: FETCH_BRANCH_STATS_EN.
module fetch_redirect_unit #(
    parameter int                     PC_WIDTH    = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   switch_branch,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   stall,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid,
    output logic                   flush_id_ex
`ifdef FETCH_BRANCH_STATS_EN
    ,
    output logic [31:0]            taken_branch_count
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    tgt_q, tgt_d;
    logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
    logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [PC_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
    logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic                   if_id_valid_q, if_id_valid_d;

    logic                   accept;
    logic [PC_WIDTH-1:0]    target_aligned;
    logic [PC_WIDTH-1:0]    pc_plus4;

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(4);
    endfunction

    // Held low during reset so nothing is requested until the first cycle after release.
    assign imem_req       = reset && (state_q != HOLD);
    assign imem_addr      = pc_q;
    assign accept         = imem_req && imem_ready;
    assign target_aligned = branch_target & ~PC_WIDTH'(3);
    assign pc_plus4       = pc_inc(pc_q);

    assign pc_out      = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign flush_id_ex = switch_branch;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (switch_branch) begin
                        pc_d          = target_aligned;
                        if_id_valid_d = 1'b0;
                        if_id_instr_d = NOP_INSTR;
                    end else if (stall) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata;
                        pc_d         = pc_plus4;
                        state_d      = HOLD;
                    end else begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end else if (switch_branch) begin
                    // The in-flight request must still complete before the redirect can issue.
                    tgt_d         = target_aligned;
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    state_d       = DROP;
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end
            DROP: begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
                if (switch_branch) begin
                    tgt_d = target_aligned;
                end
                if (accept) begin
                    pc_d    = switch_branch ? target_aligned : tgt_q;
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (switch_branch) begin
                    pc_d          = target_aligned;
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    state_d       = RUN;
                end else if (!stall) begin
                    if_id_pc_d    = hold_pc_q;
                    if_id_instr_d = hold_instr_q;
                    if_id_valid_d = 1'b1;
                    state_d       = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            tgt_q         <= '0;
            hold_pc_q     <= '0;
            hold_instr_q  <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef FETCH_BRANCH_STATS_EN
    logic [31:0] br_cnt_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt_q <= '0;
        end else if (switch_branch) begin
            br_cnt_q <= sat_inc32(br_cnt_q);
        end
    end

    assign taken_branch_count = br_cnt_q;
`endif

endmodule
